// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the PC sequencing logic.
//   - pc_state_e : sequencer state encodings (RUN / EXC_BUB / HALT)
//   - DEF_RESET_PC, DEF_EXC_VECTOR : default reset and exception addresses
//   - br_taken() : conditional branch resolution
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_EXC_BUB = 2'd1,
        ST_HALT    = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0800;

    // BEQ takes on equal, BNE takes on not-equal.
    function automatic logic br_taken(input logic branch,
                                      input logic bne_or_beq,
                                      input logic equal);
        return branch & (equal ^ bne_or_beq);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-fetch-address priority mux.
// Priority: ERET > JR > J > taken branch > PC+4.
// Ports:
//   pc_i          current PC
//   branch_i, bne_or_beq_i, equal_i  branch decode / compare result
//   jump_i, is_jr_i, is_eret_i       redirect kinds
//   jump_index_i  instr[25:0]
//   br_offset_i   sign-extended word offset
//   jr_target_i   register target
//   cp0_epc_i     ERET return address
//   target_o      selected next PC
//   misaligned_o  target_o[1:0] != 0
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        branch_i,
    input  logic        bne_or_beq_i,
    input  logic        equal_i,
    input  logic        jump_i,
    input  logic        is_jr_i,
    input  logic        is_eret_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] br_offset_i,
    input  logic [31:0] jr_target_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign pc4    = pc_i + 32'd4;
    assign br_tgt = pc4 + {br_offset_i[29:0], 2'b00};
    // J stays inside the 256 MB region of the delay-slot-free successor.
    assign j_tgt  = {pc4[31:28], jump_index_i, 2'b00};

    always_comb begin
        target_o = pc4;
        if (is_eret_i)
            target_o = cp0_epc_i;
        else if (is_jr_i)
            target_o = jr_target_i;
        else if (jump_i)
            target_o = j_tgt;
        else if (br_taken(branch_i, bne_or_beq_i, equal_i))
            target_o = br_tgt;
    end

    assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the MIPS program counter and the fetch sequencing FSM.
// States RUN / EXC_BUB (one bubble on exception entry) / HALT.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall, fetch_ready    hold conditions
//   branch, bne_or_beq, equal, jump, is_jr, is_eret  redirect decode
//   has_exp               exception from current instruction
//   halt_req, resume      enter / leave HALT
//   jump_index, br_offset, jr_target, cp0_epc  target sources
//   pc, pc_valid          fetch address and its validity
//   exc_pc, exc_take      EPC value and its one-cycle capture strobe
//   retired               advanced-instruction counter
//   addr_exc              misaligned-target exception pulse
// Build option: PC_SEQ_ALIGN_CHECK_EN turns misaligned targets into
// exceptions; without it targets are used verbatim and addr_exc is 0.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        branch,
    input  logic        bne_or_beq,
    input  logic        equal,
    input  logic        jump,
    input  logic        is_jr,
    input  logic        is_eret,
    input  logic        has_exp,
    input  logic        halt_req,
    input  logic        resume,
    input  logic [25:0] jump_index,
    input  logic [31:0] br_offset,
    input  logic [31:0] jr_target,
    input  logic [31:0] cp0_epc,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] exc_pc,
    output logic        exc_take,
    output logic [31:0] retired,
    output logic        addr_exc
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_take_q, exc_take_d;
    logic [31:0] retired_q, retired_d;
    logic        addr_exc_q, addr_exc_d;

    logic [31:0] target;
    logic        misaligned;
    logic        adv;

    next_pc_sel u_sel (
        .pc_i         (pc_q),
        .branch_i     (branch),
        .bne_or_beq_i (bne_or_beq),
        .equal_i      (equal),
        .jump_i       (jump),
        .is_jr_i      (is_jr),
        .is_eret_i    (is_eret),
        .jump_index_i (jump_index),
        .br_offset_i  (br_offset),
        .jr_target_i  (jr_target),
        .cp0_epc_i    (cp0_epc),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    assign adv = (state_q == ST_RUN) & pc_valid_q & fetch_ready & ~stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        exc_pc_d   = exc_pc_q;
        exc_take_d = 1'b0;
        retired_d  = retired_q;
        addr_exc_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                // has_exp wins over stall, fetch_ready and halt_req.
                if (has_exp) begin
                    pc_d       = EXC_VECTOR;
                    exc_pc_d   = pc_q;
                    exc_take_d = 1'b1;
                    pc_valid_d = 1'b0;
                    state_d    = ST_EXC_BUB;
                end else if (adv) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
                    if (misaligned) begin
                        pc_d       = EXC_VECTOR;
                        exc_pc_d   = target;
                        exc_take_d = 1'b1;
                        addr_exc_d = 1'b1;
                        pc_valid_d = 1'b0;
                        state_d    = ST_EXC_BUB;
                    end else
`endif
                    begin
                        pc_d      = target;
                        retired_d = retired_q + 32'd1;
                        if (halt_req) begin
                            pc_valid_d = 1'b0;
                            state_d    = ST_HALT;
                        end
                    end
                end
            end
            ST_EXC_BUB: begin
                pc_valid_d = 1'b1;
                state_d    = ST_RUN;
            end
            ST_HALT: begin
                if (resume) begin
                    pc_valid_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
        endcase
    end

`ifndef PC_SEQ_ALIGN_CHECK_EN
    // Misalignment is only consumed by alignment-check builds.
    logic sel_unused;
    assign sel_unused = misaligned;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b1;
            exc_pc_q   <= 32'd0;
            exc_take_q <= 1'b0;
            retired_q  <= 32'd0;
            addr_exc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            exc_pc_q   <= exc_pc_d;
            exc_take_q <= exc_take_d;
            retired_q  <= retired_d;
            addr_exc_q <= addr_exc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign exc_pc   = exc_pc_q;
    assign exc_take = exc_take_q;
    assign retired  = retired_q;
    assign addr_exc = addr_exc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_V  = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_ready, branch, bne_or_beq, equal;
    logic        jump, is_jr, is_eret, has_exp, halt_req, resume;
    logic [25:0] jump_index;
    logic [31:0] br_offset, jr_target, cp0_epc;
    logic [31:0] pc, exc_pc, retired;
    logic        pc_valid, exc_take, addr_exc;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .branch(branch), .bne_or_beq(bne_or_beq), .equal(equal),
        .jump(jump), .is_jr(is_jr), .is_eret(is_eret), .has_exp(has_exp),
        .halt_req(halt_req), .resume(resume), .jump_index(jump_index),
        .br_offset(br_offset), .jr_target(jr_target), .cp0_epc(cp0_epc),
        .pc(pc), .pc_valid(pc_valid), .exc_pc(exc_pc), .exc_take(exc_take),
        .retired(retired), .addr_exc(addr_exc)
    );

    // Reference model: architectural view of the sequencer.
    logic [31:0] m_pc, m_exc_pc, m_ret;
    bit          m_valid, m_take, m_aexc, m_halted, m_bubble;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        reset = 0; stall = 0; fetch_ready = 1; branch = 0; bne_or_beq = 0;
        equal = 0; jump = 0; is_jr = 0; is_eret = 0; has_exp = 0;
        halt_req = 0; resume = 0; jump_index = '0; br_offset = '0;
        jr_target = '0; cp0_epc = '0;
    endtask

    // Apply current inputs for one edge, update model, compare everything.
    task automatic step();
        logic [31:0] p4, tgt;
        if (reset) begin
            m_pc = RST_PC; m_valid = 1; m_halted = 0; m_bubble = 0;
            m_exc_pc = 0; m_take = 0; m_ret = 0; m_aexc = 0;
        end else begin
            m_take = 0; m_aexc = 0;
            if (m_bubble) begin
                m_bubble = 0; m_valid = 1;
            end else if (m_halted) begin
                if (resume) begin m_halted = 0; m_valid = 1; end
            end else if (has_exp) begin
                m_exc_pc = m_pc; m_pc = EXC_V; m_take = 1; m_valid = 0; m_bubble = 1;
            end else if (fetch_ready && !stall) begin
                p4 = m_pc + 32'd4;
                if (is_eret)                               tgt = cp0_epc;
                else if (is_jr)                            tgt = jr_target;
                else if (jump)                             tgt = {p4[31:28], jump_index, 2'b00};
                else if (branch && (equal != bne_or_beq))  tgt = p4 + br_offset * 4;
                else                                       tgt = p4;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                if (tgt % 4 != 0) begin
                    m_exc_pc = tgt; m_pc = EXC_V; m_take = 1; m_aexc = 1;
                    m_valid = 0; m_bubble = 1;
                end else
`endif
                begin
                    m_pc = tgt; m_ret = m_ret + 1;
                    if (halt_req) begin m_halted = 1; m_valid = 0; end
                end
            end
        end
        @(posedge clk); #1;
        chk("pc", pc, m_pc);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        chk("exc_pc", exc_pc, m_exc_pc);
        chk("exc_take", {31'd0, exc_take}, {31'd0, m_take});
        chk("retired", retired, m_ret);
        chk("addr_exc", {31'd0, addr_exc}, {31'd0, m_aexc});
    endtask

    task automatic go_to(input logic [31:0] a);
        idle(); is_jr = 1; jr_target = a; step(); idle();
    endtask

    initial begin
        logic [31:0] held;
        idle();
        m_pc = 0; m_exc_pc = 0; m_ret = 0; m_valid = 1;
        m_take = 0; m_aexc = 0; m_halted = 0; m_bubble = 0;

        // Reset state
        reset = 1; step(); step(); idle();
        chk("rst_pc", pc, RST_PC);
        chk("rst_ret", retired, 32'd0);

        // Three sequential advances
        step(); step(); step();
        chk("seq_pc", pc, 32'h0000_000C);
        chk("seq_ret", retired, 32'd3);

        // BEQ taken / BNE not taken
        go_to(32'h0040_0000);
        branch = 1; equal = 1; bne_or_beq = 0; br_offset = 32'd4; step(); idle();
        chk("beq_taken", pc, 32'h0040_0014);
        go_to(32'h0040_0000);
        branch = 1; equal = 1; bne_or_beq = 1; br_offset = 32'd4; step(); idle();
        chk("bne_not_taken", pc, 32'h0040_0004);

        // J, then JR beating J
        go_to(32'h0040_0000);
        jump = 1; jump_index = 26'h1234; step(); idle();
        chk("j_target", pc, 32'h0000_48D0);
        jump = 1; is_jr = 1; jr_target = 32'h9000_0000; step(); idle();
        chk("jr_over_j", pc, 32'h9000_0000);

        // Exception under stall, bubble, ERET
        go_to(32'h0040_0010);
        has_exp = 1; stall = 1; step(); idle();
        chk("exc_pc_vec", pc, EXC_V);
        chk("exc_valid0", {31'd0, pc_valid}, 32'd0);
        chk("exc_epc", exc_pc, 32'h0040_0010);
        chk("exc_take1", {31'd0, exc_take}, 32'd1);
        has_exp = 1; jump = 1; step(); idle();   // bubble ignores inputs
        chk("bub_valid1", {31'd0, pc_valid}, 32'd1);
        chk("bub_take0", {31'd0, exc_take}, 32'd0);
        is_eret = 1; cp0_epc = 32'h0040_0014; step(); idle();
        chk("eret", pc, 32'h0040_0014);

        // Stall / fetch_ready hold
        stall = 1; step(); step(); stall = 0; fetch_ready = 0; step(); idle();
        chk("hold_pc", pc, 32'h0040_0014);

        // HALT with resume held during entry, then resume
        halt_req = 1; resume = 1; step(); idle();
        held = pc;
        for (int i = 0; i < 5; i++) begin has_exp = (i == 2); step(); end
        idle();
        chk("halt_frozen", pc, held);
        resume = 1; step(); idle();
        chk("resume_valid", {31'd0, pc_valid}, 32'd1);

        // Reset while halted
        halt_req = 1; step(); idle();
        reset = 1; step(); idle();
        chk("halt_rst_pc", pc, RST_PC);
        step();

        // Misaligned JR target
        go_to(32'h0040_0000);
        is_jr = 1; jr_target = 32'h0040_0002; step(); idle();
`ifdef PC_SEQ_ALIGN_CHECK_EN
        chk("align_pc", pc, EXC_V);
        chk("align_epc", exc_pc, 32'h0040_0002);
        chk("align_flag", {31'd0, addr_exc}, 32'd1);
`else
        chk("noalign_pc", pc, 32'h0040_0002);
`endif
        reset = 1; step(); idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(99) == 0);
            stall       = ($urandom_range(5) == 0);
            fetch_ready = ($urandom_range(5) != 0);
            branch      = $urandom_range(1);
            bne_or_beq  = $urandom_range(1);
            equal       = $urandom_range(1);
            jump        = ($urandom_range(5) == 0);
            is_jr       = ($urandom_range(7) == 0);
            is_eret     = ($urandom_range(11) == 0);
            has_exp     = ($urandom_range(15) == 0);
            halt_req    = ($urandom_range(15) == 0);
            resume      = ($urandom_range(3) == 0);
            jump_index  = 26'($urandom);
            br_offset   = {{16{1'b0}}, 16'($urandom)};
            if ($urandom_range(1)) br_offset = {{16{1'b1}}, br_offset[15:0]};
            jr_target   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(15) == 0) jr_target[1:0] = 2'($urandom_range(3));
            cp0_epc     = $urandom & 32'hFFFF_FFFC;
            step();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
